// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester arbiter that runs each access to data_mem
// as a registered IDLE -> ISSUE -> DONE transaction.
module data_mem_arbiter #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 16,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              sig_mem_write,
    output logic              sig_mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t state_q, state_d;
    logic gnt_q, gnt_d, we_q, we_d, last_gnt_q, last_gnt_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic wr_q, wr_d, rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic win;

    // On contention the requester not served last wins unless priority is fixed.
    assign win = (req0 && req1) ? ((FIXED_PRI != 0) ? 1'b0 : !last_gnt_q) : req1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        busy_d     = busy_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        case (state_q)
            IDLE: if (req0 || req1) begin
                gnt_d   = win;
                we_d    = win ? we1 : we0;
                addr_d  = win ? addr1 : addr0;
                wdata_d = win ? wdata1 : wdata0;
                wr_d    = we_d;
                rd_d    = !we_d;
                busy_d  = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                ack0_d     = !gnt_q;
                ack1_d     = gnt_q;
                rdata0_d   = (!we_q && !gnt_q) ? mem_read_data : rdata0_q;
                rdata1_d   = (!we_q && gnt_q) ? mem_read_data : rdata1_q;
                last_gnt_d = gnt_q;
                state_d    = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign busy           = busy_q;
    assign sig_mem_write  = wr_q;
    assign sig_mem_read   = rd_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer in front of the 8×16-bit `data_mem` block. It shares the single memory port between the pipeline's load/store stage (requester 0) and the debug/loader port (requester 1). Each access runs as a registered three-phase transaction. The block guarantees `data_mem` never sees read and write asserted together.

## Interface
Parameters:
- `ADDR_W`, 3, memory address width
- `DATA_W`, 16, memory data width
- `FIXED_PRI`, 0, 0 = round-robin, 1 = requester 0 always wins

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  access request, held until the matching ack
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while req high
- `addr0` / `addr1`  in  ADDR_W  word address; stable while req high
- `wdata0` / `wdata1`  in  DATA_W  write data; stable while req high
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  read result, valid from the ack cycle and held until that requester's next read completes
- `busy`  out  1  high in ISSUE and DONE
- `sig_mem_write`  out  1  to `data_mem` write enable
- `sig_mem_read`  out  1  to `data_mem` read enable
- `mem_addr`  out  ADDR_W  to `data_mem` addr
- `mem_write_data`  out  DATA_W  to `data_mem` write_data
- `mem_read_data`  in  DATA_W  from `data_mem` read_data_out

## Operation
- FSM states: IDLE, ISSUE, DONE. All outputs are registered.
- IDLE:
  - If no request is high, stay in IDLE.
  - Otherwise select a winner and latch its id, we, addr and wdata. Go to ISSUE.
- Winner selection:
  - Only one request high: that requester wins.
  - Both high, `FIXED_PRI`=1: requester 0 wins.
  - Both high, `FIXED_PRI`=0: the requester not granted last wins (`last_gnt` register).
- ISSUE (exactly one cycle):
  - `mem_addr` and `mem_write_data` are driven from the latch.
  - Exactly one of `sig_mem_write` (we=1) or `sig_mem_read` (we=0) is high. Go to DONE.
- DONE (exactly one cycle):
  - Both strobes are low; `mem_addr` and `mem_write_data` hold their values.
  - The winner's ack goes high.
  - On a read, `mem_read_data` is sampled at the ISSUE→DONE edge into the winner's rdata. On a write, rdata is unchanged.
  - `last_gnt` takes the winner's id. Go to IDLE.
- The loser's request stays pending and is served next. There is no queueing beyond the held req line.
- If req is still high in the IDLE cycle after the ack, it is a new request (back-to-back allowed).
- Dropping req before its ack is illegal. The latched transaction completes regardless.
- `data_mem` contents are never reset by this block.

## Timing
- Reset values:
  - state=IDLE, `last_gnt`=1 (first contended grant goes to requester 0)
  - `ack0`, `ack1`, `busy`, `sig_mem_write`, `sig_mem_read` = 0
  - `mem_addr`=0, `mem_write_data`=0, `rdata0`=0, `rdata1`=0
- Reset in ISSUE or DONE: the transaction is abandoned. No ack is issued. All outputs take their reset values at that edge, and the requester must re-request.
- Latency and throughput:
  - A req sampled high in IDLE at edge n gives strobe high in cycle n+1 and ack high in cycle n+2.
  - One access per 3 cycles at most.
- Strobes are single-cycle pulses and are mutually exclusive in every cycle.
- `busy` is 0 in IDLE and 1 in ISSUE/DONE.
- Round-robin fairness: under continuous contention the grants alternate 0,1,0,1. The maximum wait for a request is one foreign transaction plus its own (6 cycles).

## Test plan
- Reset, then req0 read addr 0 (memory reset image: 69 at addr 0) → `sig_mem_read` high for 1 cycle, `ack0` 2 cycles after sampling, `rdata0`=69, `sig_mem_write` never high.
- req1 write addr 6 data 55, then req0 read addr 6 → `sig_mem_write` pulse with `mem_addr`=6, `mem_write_data`=55; `ack1`; later `rdata0`=55; `rdata1` unchanged (0).
- `FIXED_PRI`=0, req0 and req1 both held high for 4 transactions (reads of addr 2 and addr 0) → grant order 0,1,0,1; `rdata0`=9, `rdata1`=69; one ack every 3 cycles.
- `FIXED_PRI`=1, both requesting continuously for 3 transactions → requester 0 served every time, `ack1` never pulses while req0 stays high.
- Assert `rst` during ISSUE of a req1 write to addr 3 data 1234 → next cycle all outputs at reset values, no `ack1`, state IDLE; re-request completes normally.
- Random req/we/addr for 1000 cycles → checker confirms strobes are never both high, exactly one ack per granted request, and rdata matches a scoreboard model of memory.
